// File: rtl/button_irq.sv
// Debounced push-button interrupt source with a single CSR holding enable, pending,
// stable levels and a free-running press counter.
module button_irq #(
  parameter int          NumButtons     = 4,
  parameter int          DebounceCycles = 20000,
  parameter logic [11:0] Addr           = 12'h7C0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NumButtons-1:0] buttons,
  input  logic                  csr_enable,
  input  logic [11:0]           csr_addr,
  input  logic [2:0]            csr_op,
  input  logic [4:0]            rs1_zimm,
  input  logic [31:0]           rs1_data,
  output logic [31:0]           csr_out,
  output logic                  ext_interrupt
);

  localparam int CntW = $clog2(DebounceCycles);
  localparam logic [CntW-1:0] CntMax = CntW'(DebounceCycles - 1);

  logic [NumButtons-1:0] sync1;
  logic [NumButtons-1:0] sample;
  logic [NumButtons-1:0] stable;
  logic [NumButtons-1:0] stable_q;
  logic [NumButtons-1:0] press;
  logic [CntW-1:0]       cnt [NumButtons];

  logic [NumButtons-1:0] enable;
  logic [NumButtons-1:0] pending;
  logic [7:0]            press_cnt;

  logic [7:0]            enable_f, pending_f, stable_f;
  logic [31:0]           csr_cur;
  logic [31:0]           wr_src;
  logic [31:0]           csr_new;
  logic                  csr_hit;
  logic [3:0]            n_press;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1  <= '0;
      sample <= '0;
    end else begin
      sync1  <= buttons;
      sample <= sync1;
    end
  end

  for (genvar i = 0; i < NumButtons; i++) begin : g_debounce
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        stable[i] <= 1'b0;
        cnt[i]    <= '0;
      end else if (sample[i] == stable[i]) begin
        cnt[i] <= '0;
      end else if (cnt[i] == CntMax) begin
        stable[i] <= sample[i];
        cnt[i]    <= '0;
      end else begin
        cnt[i] <= cnt[i] + CntW'(1);
      end
    end
  end

  // Press events are taken one cycle after the stable level rises.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) stable_q <= '0;
    else       stable_q <= stable;
  end

  assign press = stable & ~stable_q;

  always_comb begin
    enable_f  = '0;
    pending_f = '0;
    stable_f  = '0;
    enable_f[NumButtons-1:0]  = enable;
    pending_f[NumButtons-1:0] = pending;
    stable_f[NumButtons-1:0]  = stable;
  end

  assign csr_cur = {press_cnt, stable_f, pending_f, enable_f};
  assign csr_out = (csr_addr == Addr) ? csr_cur : '0;
  assign csr_hit = csr_enable && (csr_addr == Addr);
  assign wr_src  = csr_op[2] ? {27'd0, rs1_zimm} : rs1_data;

  // csr_op[1:0]: 01 write, 10 set, 11 clear; bit 2 selects the immediate source.
  always_comb begin
    csr_new = csr_cur;
    if (csr_hit) begin
      case (csr_op[1:0])
        2'b01:   csr_new = wr_src;
        2'b10:   csr_new = csr_cur | wr_src;
        2'b11:   csr_new = csr_cur & ~wr_src;
        default: csr_new = csr_cur;
      endcase
    end
  end

  always_comb begin
    n_press = '0;
    for (int i = 0; i < NumButtons; i++) begin
      n_press = n_press + {3'd0, press[i]};
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      enable        <= '0;
      pending       <= '0;
      press_cnt     <= '0;
      ext_interrupt <= 1'b0;
    end else begin
      enable        <= csr_new[NumButtons-1:0];
      pending       <= csr_new[8 +: NumButtons] | press;
      press_cnt     <= press_cnt + {4'd0, n_press};
      ext_interrupt <= |(press & enable);
    end
  end

endmodule

// File: tb/tb_button_irq.sv
// Randomized bench for button_irq with a window-based debounce reference model and
// an interrupt-pulse scoreboard.
module tb_button_irq;

  localparam int          NB   = 4;
  localparam int          DB   = 4;
  localparam logic [11:0] ADDR = 12'h7C0;

  localparam logic [2:0] OP_RW  = 3'b001;
  localparam logic [2:0] OP_RS  = 3'b010;
  localparam logic [2:0] OP_RC  = 3'b011;
  localparam logic [2:0] OP_RSI = 3'b110;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [NB-1:0] buttons = '0;
  logic          csr_enable = 1'b0;
  logic [11:0]   csr_addr = ADDR;
  logic [2:0]    csr_op = 3'b000;
  logic [4:0]    rs1_zimm = '0;
  logic [31:0]   rs1_data = '0;
  logic [31:0]   csr_out;
  logic          ext_interrupt;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  bit started = 0;

  button_irq #(.NumButtons(NB), .DebounceCycles(DB), .Addr(ADDR)) dut (
    .clk(clk), .reset(reset), .buttons(buttons),
    .csr_enable(csr_enable), .csr_addr(csr_addr), .csr_op(csr_op),
    .rs1_zimm(rs1_zimm), .rs1_data(rs1_data),
    .csr_out(csr_out), .ext_interrupt(ext_interrupt)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference model: pin history window, stable levels, register fields.
  logic [NB-1:0] hist [5];
  int            age [NB];
  logic [NB-1:0] m_stable = '0, m_press = '0, m_en = '0, m_pend = '0, new_press;
  logic [7:0]    m_cnt = '0;
  int            total_press = 0;
  int            exp_q [$];
  logic [31:0]   src;
  logic [NB-1:0] ne, np;
  bit            all_diff;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_stable = '0; m_press = '0; m_en = '0; m_pend = '0; m_cnt = '0;
      for (int k = 0; k < 5; k++) hist[k] = '0;
      for (int i = 0; i < NB; i++) age[i] = 99;
      exp_q.delete();
    end else begin
      ne  = m_en;
      np  = m_pend;
      src = csr_op[2] ? {27'd0, rs1_zimm} : rs1_data;
      if (csr_enable && csr_addr == ADDR) begin
        case (csr_op[1:0])
          2'b01: begin ne = src[NB-1:0];       np = src[8 +: NB];        end
          2'b10: begin ne = m_en | src[NB-1:0]; np = m_pend | src[8 +: NB]; end
          2'b11: begin ne = m_en & ~src[NB-1:0]; np = m_pend & ~src[8 +: NB]; end
          default: ;
        endcase
      end
      if (|(m_press & m_en)) exp_q.push_back(cyc + 1);
      np          = np | m_press;
      m_cnt       = m_cnt + 8'($countones(m_press));
      total_press = total_press + $countones(m_press);
      m_en        = ne;
      m_pend      = np;
      // A level is accepted once the last DB synchronized samples all disagree
      // with it and no acceptance happened inside that window.
      for (int i = 0; i < NB; i++) begin
        all_diff = (hist[1][i] != m_stable[i]) && (hist[2][i] != m_stable[i]) &&
                   (hist[3][i] != m_stable[i]) && (hist[4][i] != m_stable[i]);
        if (age[i] >= DB - 1 && all_diff) begin
          new_press[i] = ~m_stable[i];
          m_stable[i]  = ~m_stable[i];
          age[i]       = 0;
        end else begin
          new_press[i] = 1'b0;
          if (age[i] < 99) age[i]++;
        end
      end
      m_press = new_press;
      for (int k = 4; k > 0; k--) hist[k] = hist[k-1];
      hist[0] = buttons;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: register image every cycle, interrupt pulses against the scoreboard.
  always @(negedge clk) begin
    if (started) begin
      check("csr_out", csr_out,
            (csr_addr == ADDR) ? {m_cnt, 4'd0, m_stable, 4'd0, m_pend, 4'd0, m_en} : 32'd0);
      if (ext_interrupt) begin
        if (exp_q.size() == 0) begin
          tests++; fails++;
          $display("FAIL irq_unexpected: pulse at cycle %0d, none expected", cyc);
        end else begin
          check("irq_cycle", cyc, exp_q.pop_front());
        end
      end
    end
  end

  task automatic step(input int n = 1);
    repeat (n) begin @(posedge clk); #2; end
  endtask

  task automatic csr_access(input logic [2:0] op, input logic [31:0] data, input logic [4:0] zimm);
    csr_enable = 1'b1; csr_op = op; rs1_data = data; rs1_zimm = zimm;
    step();
    csr_enable = 1'b0; csr_op = 3'b000;
  endtask

  initial begin
    int c0;
    bit got;
    logic [2:0] ops [6] = '{3'b001, 3'b010, 3'b011, 3'b101, 3'b110, 3'b111};

    step(3);
    reset = 1'b0;
    started = 1;
    #1 check("reset_csr", csr_out, 32'h0);
    check("reset_irq", {31'd0, ext_interrupt}, 32'h0);
    step(2);

    // Single enabled press: pulse 7 cycles after the pin edge.
    csr_access(OP_RSI, 32'h0, 5'd1);
    buttons = 4'b0001;
    c0 = cyc;
    got = 0;
    for (int k = 0; k < 12 && !got; k++) begin
      @(negedge clk);
      if (ext_interrupt) got = 1;
    end
    check("press_latency", got ? cyc - c0 : -1, 7);
    step(4);
    check("csr_after_press", csr_out, 32'h0101_0101);

    // Glitch shorter than the debounce window.
    buttons = 4'b0011; step(3);
    buttons = 4'b0001; step(8);
    check("glitch_stable", {31'd0, csr_out[17]}, 32'h0);
    check("glitch_count", {24'd0, csr_out[31:24]}, 32'h1);

    // Disabled button: pending and count only.
    buttons = 4'b0101; step(10);
    check("dis_pending", {31'd0, csr_out[10]}, 32'h1);
    check("dis_count", {24'd0, csr_out[31:24]}, 32'h2);
    csr_access(OP_RC, 32'h400, 5'd0);
    #1 check("dis_clear", {31'd0, csr_out[10]}, 32'h0);

    // Simultaneous enabled presses.
    buttons = 4'b0000; step(10);
    csr_access(OP_RS, 32'h9, 5'd0);
    buttons = 4'b1001; step(10);
    check("simul_pending", {24'd0, csr_out[15:8]}, 32'h09);
    check("simul_count", {24'd0, csr_out[31:24]}, 32'h4);

    // Random pins, glitches and CSR traffic.
    for (int it = 0; it < 60; it++) begin
      buttons = NB'($urandom_range(0, 15));
      if ($urandom_range(0, 2) == 0) begin
        csr_addr = ($urandom_range(0, 3) == 0) ? ADDR + 12'd1 : ADDR;
        csr_access(ops[$urandom_range(0, 5)], $urandom, 5'($urandom_range(0, 31)));
        csr_addr = ADDR;
      end
      step($urandom_range(1, 8));
    end
    buttons = '0; step(10);

    // Drive the press counter to exactly 256 so it wraps.
    for (int k = 0; k < 300 && total_press < 256; k++) begin
      buttons = 4'b0010; step(7);
      buttons = 4'b0000; step(7);
    end
    check("count_wrap", {24'd0, csr_out[31:24]}, 32'h0);

    // Software clear racing a hardware set on pending[0].
    csr_access(OP_RS, 32'h100, 5'd0);
    csr_access(OP_RW, 32'h101, 5'd0);
    buttons = 4'b0001;
    step(6);
    csr_access(OP_RC, 32'h100, 5'd0);
    #1 check("race_pending", {31'd0, csr_out[8]}, 32'h1);
    step(4);

    // Reset in the middle of a debounce count.
    buttons = '0; step(8);
    csr_access(OP_RSI, 32'h0, 5'd15);
    buttons = 4'b0100; step(4);
    reset = 1'b1; buttons = '0;
    #1 check("midreset_csr", csr_out, 32'h0);
    check("midreset_irq", {31'd0, ext_interrupt}, 32'h0);
    step(2);
    reset = 1'b0;
    step(15);
    check("post_reset_csr", csr_out, 32'h0);

    // Button held through reset release.
    buttons = 4'b0001; step(2);
    reset = 1'b1; step(2);
    reset = 1'b0;
    csr_access(OP_RSI, 32'h0, 5'd1);
    step(12);
    check("held_stable", {31'd0, csr_out[16]}, 32'h1);
    check("held_count", {24'd0, csr_out[31:24]}, 32'h1);

    buttons = '0; step(10);
    check("irq_queue_empty", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
